sn74ls194_seq: RTL and testbench

- Sequencer that drives the mode-select and serial inputs of one 4-bit bidirectional shift register, or a cascaded chain of them.
- On a start request it optionally issues one parallel-load cycle, then exactly N shift cycles in a chosen direction. It then pulses done and returns to idle.
- Sits between a host state machine and the register's s1/s0/r/l pins. The register's own active-low clear is not driven by this block.

---
 rtl/sn74ls194_seq_if.sv | 30 +++
 rtl/sn74ls194_seq.sv | 148 ++++++++++++++
 tb/tb_sn74ls194_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sn74ls194_seq_if.sv
// Host-side bundle for the 74LS194 shift sequencer.
// Carries the start request fields and the register drive/status outputs.
interface sn74ls194_seq_if #(
  parameter int CW = 4
) ();
  logic          start;
  logic          load_en;
  logic          dir;
  logic [CW-1:0] count;
  logic          fill;
  logic          abort;
  logic          s1;
  logic          s0;
  logic          sr_r;
  logic          sr_l;
  logic          ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;

  modport master (
    output start, load_en, dir, count, fill, abort,
    input  s1, s0, sr_r, sr_l, ready, busy, done, remaining
  );

  modport slave (
    input  start, load_en, dir, count, fill, abort,
    output s1, s0, sr_r, sr_l, ready, busy, done, remaining
  );
endinterface

// File: rtl/sn74ls194_seq.sv
// Mode/serial sequencer for a 74LS194 chain: optional load, then N shifts.
// Every output is a flop, computed from the next state and fields.
module sn74ls194_seq #(
  parameter int CW = 4
) (
  input logic           clk,
  input logic           clr,
  sn74ls194_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, DONE
  } state_t;

  state_t        st, st_n;
  logic          dir_q, dir_n;
  logic          fill_q, fill_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [CW-1:0] rem_q, rem_n;

  logic s1_q, s0_q, r_q, l_q;
  logic rdy_q, busy_q, done_q;
  logic s1_n, s0_n, r_n, l_n;
  logic rdy_n, busy_n, done_n;

  always_comb begin
    st_n   = st;
    dir_n  = dir_q;
    fill_n = fill_q;
    cnt_n  = cnt_q;
    rem_n  = rem_q;
    unique case (st)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          dir_n  = bus.dir;
          fill_n = bus.fill;
          cnt_n  = bus.count;
          rem_n  = bus.count;
          if (bus.load_en)
            st_n = LOAD;
          else if (bus.count != '0)
            st_n = SHIFT;
          else
            st_n = DONE;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          st_n  = IDLE;
          rem_n = '0;
        end else if (cnt_q != '0) begin
          st_n = SHIFT;
        end else begin
          st_n  = DONE;
          rem_n = '0;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          st_n  = IDLE;
          rem_n = '0;
        end else if (rem_q <= 1) begin
          st_n  = DONE;
          rem_n = '0;
        end else begin
          rem_n = rem_q - 1'b1;
        end
      end
      DONE: begin
        st_n  = IDLE;
        rem_n = '0;
      end
      default: begin
        st_n  = IDLE;
        rem_n = '0;
      end
    endcase
  end

  // Register drive follows the state being entered.
  always_comb begin
    s1_n   = 1'b0;
    s0_n   = 1'b0;
    r_n    = 1'b0;
    l_n    = 1'b0;
    rdy_n  = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    unique case (1'b1)
      (st_n == LOAD): begin
        s1_n   = 1'b1;
        s0_n   = 1'b1;
        busy_n = 1'b1;
      end
      (st_n == SHIFT): begin
        s1_n   = dir_n;
        s0_n   = !dir_n;
        r_n    = !dir_n && fill_n;
        l_n    = dir_n && fill_n;
        busy_n = 1'b1;
      end
      (st_n == DONE): begin
        done_n = 1'b1;
      end
      default: begin
        rdy_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st     <= IDLE;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      s1_q   <= 1'b0;
      s0_q   <= 1'b0;
      r_q    <= 1'b0;
      l_q    <= 1'b0;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      dir_q  <= dir_n;
      fill_q <= fill_n;
      cnt_q  <= cnt_n;
      rem_q  <= rem_n;
      s1_q   <= s1_n;
      s0_q   <= s0_n;
      r_q    <= r_n;
      l_q    <= l_n;
      rdy_q  <= rdy_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.s1        = s1_q;
  assign bus.s0        = s0_q;
  assign bus.sr_r      = r_q;
  assign bus.sr_l      = l_q;
  assign bus.ready     = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;
endmodule

// File: tb/tb_sn74ls194_seq.sv
// Directed bench for sn74ls194_seq driving a behavioural 74LS194.
// Checks mode sequences, latency, remaining count and register contents.
module tb_sn74ls194_seq;
  logic clk;
  logic clr;
  logic [3:0] q;
  logic [3:0] d;
  logic       pre_en;
  logic [3:0] pre_v;
  int n_chk;
  int n_fail;

  sn74ls194_seq_if #(.CW(4)) bus ();

  sn74ls194_seq #(.CW(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en)
      q <= pre_v;
    else
      case ({bus.s1, bus.s0})
        2'b11:   q <= d;
        2'b01:   q <= {q[2:0], bus.sr_r};
        2'b10:   q <= {bus.sr_l, q[3:1]};
        default: q <= q;
      endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [3:0] v);
    pre_v  = v;
    pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic op(input logic ld, input logic dr,
                    input logic [3:0] n, input logic f);
    int lat, nsh, nld, ndone;
    logic [1:0] sv;
    lat = 0; nsh = 0; nld = 0; ndone = 0;
    bus.load_en = ld;
    bus.dir     = dr;
    bus.count   = n;
    bus.fill    = f;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      sv = {bus.s1, bus.s0};
      if (sv == 2'b11) begin
        nld++;
        chk("load_first", nsh, 0);
      end
      if (sv == 2'b01 || sv == 2'b10) begin
        chk("dir_code", int'(sv), dr ? 2 : 1);
        chk("remaining", int'(bus.remaining), int'(n) - nsh);
        chk("sr_r", int'(bus.sr_r), int'(!dr && f));
        chk("sr_l", int'(bus.sr_l), int'(dr && f));
        nsh++;
      end
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = k;
        chk("done_s", int'(sv), 0);
        chk("done_rdy", int'(bus.ready), 0);
      end
      if (bus.ready) break;
      tick();
    end
    chk("latency", lat, 1 + int'(ld) + int'(n));
    chk("n_shift", nsh, int'(n));
    chk("n_load", nld, int'(ld));
    chk("n_done", ndone, 1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    clr = 1'b1;
    d = 4'b0000;
    pre_en = 1'b0;
    pre_v = 4'b0000;
    bus.start = 1'b0;
    bus.load_en = 1'b0;
    bus.dir = 1'b0;
    bus.count = 4'd0;
    bus.fill = 1'b0;
    bus.abort = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_s", int'({bus.s1, bus.s0}), 0);
    chk("rst_sr", int'({bus.sr_r, bus.sr_l}), 0);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_rem", int'(bus.remaining), 0);

    // clr sampled on the edge of the 2nd shift
    preset(4'b0001);
    bus.count = 4'd5;
    bus.dir = 1'b0;
    bus.fill = 1'b0;
    bus.load_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("mid_busy", int'(bus.busy), 1);
    chk("mid_rem", int'(bus.remaining), 5);
    tick();
    clr = 1'b1;
    tick();
    chk("clr_done0", int'(bus.done), 0);
    tick();
    chk("clr_done1", int'(bus.done), 0);
    clr = 1'b0;
    chk("clr_s", int'({bus.s1, bus.s0}), 0);
    chk("clr_ready", int'(bus.ready), 1);
    chk("clr_busy", int'(bus.busy), 0);
    tick();
    chk("clr_done2", int'(bus.done), 0);
    chk("clr_q", int'(q), 4'b0100);

    preset(4'b1010);
    d = 4'b0000;
    op(1'b1, 1'b0, 4'd3, 1'b1);
    chk("ld_right_q", int'(q), 4'b0111);

    preset(4'b1111);
    op(1'b0, 1'b1, 4'd2, 1'b0);
    chk("left_q", int'(q), 4'b0011);

    preset(4'b0110);
    op(1'b0, 1'b0, 4'd0, 1'b1);
    chk("zero_q", int'(q), 4'b0110);
    d = 4'b1001;
    op(1'b1, 1'b0, 4'd0, 1'b1);
    chk("zero_ld_q", int'(q), 4'b1001);

    // abort sampled on the edge of the 3rd shift
    preset(4'b0000);
    bus.count = 4'd6;
    bus.dir = 1'b0;
    bus.fill = 1'b1;
    bus.load_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ab_rem", int'(bus.remaining), 5);
    tick();
    chk("ab_rem2", int'(bus.remaining), 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_ready", int'(bus.ready), 1);
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_done", int'(bus.done), 0);
    chk("ab_rem0", int'(bus.remaining), 0);
    chk("ab_s", int'({bus.s1, bus.s0}), 0);
    chk("ab_sr", int'({bus.sr_r, bus.sr_l}), 0);
    tick();
    chk("ab_done1", int'(bus.done), 0);
    chk("ab_q", int'(q), 4'b0111);

    preset(4'b1111);
    op(1'b0, 1'b0, 4'd15, 1'b0);
    chk("max_q", int'(q), 4'b0000);

    preset(4'b0101);
    bus.count = 4'd3;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("as_ready", int'(bus.ready), 1);
    chk("as_busy", int'(bus.busy), 0);
    chk("as_s", int'({bus.s1, bus.s0}), 0);
    tick();
    chk("as_done", int'(bus.done), 0);
    chk("as_q", int'(q), 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
